// File: rtl/control_loop_sched.sv
// Sequences N_CH control-loop channels through one shared datapath, once per simulation step.
// Define CTRL_SCHED_WATCHDOG_EN to build the per-channel dp_done watchdog (err_timeout).
module control_loop_sched #(
  parameter int N_CH    = 4,
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      step_start,
  input  logic [N_CH-1:0]           ch_en,
  input  logic [N_CH*4*WIDTH-1:0]   ch_in,
  output logic [2:0]                dp_sel,
  output logic [WIDTH-1:0]          dp_in_1,
  output logic [WIDTH-1:0]          dp_in_2,
  output logic [WIDTH-1:0]          dp_in_3,
  output logic [WIDTH-1:0]          dp_in_4,
  output logic                      dp_sta,
  input  logic [WIDTH-1:0]          dp_out_1,
  input  logic [WIDTH-1:0]          dp_out_2,
  input  logic                      dp_done,
  output logic [N_CH*WIDTH-1:0]     res_1,
  output logic [N_CH*WIDTH-1:0]     res_2,
  output logic [N_CH-1:0]           res_valid,
  output logic                      step_done,
  output logic                      busy,
  output logic [N_CH-1:0]           err_timeout,
  output logic                      err_overrun
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, FIN} state_t;

  state_t                  state_q;
  logic [N_CH-1:0]         pend_q;
  logic [N_CH-1:0]         valid_q;
  logic [2:0]              sel_q;
  logic [4*WIDTH-1:0]      ops_q;
  logic                    sta_q;
  logic                    done_q;
  logic                    busy_q;
  logic                    ovr_q;
  logic [N_CH*WIDTH-1:0]   resOne_q;
  logic [N_CH*WIDTH-1:0]   resTwo_q;

  logic [N_CH-1:0]         curMask_d;
  logic [N_CH-1:0]         pendAfter_d;
  logic [N_CH-1:0]         pickFrom_d;
  logic [2:0]              issueIdx_d;
  logic [4*WIDTH-1:0]      issueOps_d;
  logic                    timedOut_d;

  function automatic logic [2:0] lowestIdx(input logic [N_CH-1:0] m);
    logic [2:0] idx;
    idx = '0;
    for (int i = N_CH-1; i >= 0; i--) begin
      if (m[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  // Next channel to issue: from the fresh enable mask in IDLE, otherwise from what is still pending.
  always_comb begin
    curMask_d   = N_CH'(1) << sel_q;
    pendAfter_d = pend_q & ~curMask_d;
    pickFrom_d  = (state_q == IDLE) ? ch_en : pendAfter_d;
    issueIdx_d  = lowestIdx(pickFrom_d);
    issueOps_d  = ch_in[int'(issueIdx_d)*4*WIDTH +: 4*WIDTH];
  end

`ifdef CTRL_SCHED_WATCHDOG_EN
  localparam int CW = $clog2(TIMEOUT);
  logic [CW-1:0]   cnt_q;
  logic [N_CH-1:0] errTo_q;
  assign timedOut_d  = (cnt_q == CW'(TIMEOUT-1));
  assign err_timeout = errTo_q;
`else
  assign timedOut_d  = 1'b0;
  assign err_timeout = '0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      pend_q   <= '0;
      valid_q  <= '0;
      sel_q    <= '0;
      ops_q    <= '0;
      sta_q    <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      ovr_q    <= 1'b0;
      resOne_q <= '0;
      resTwo_q <= '0;
`ifdef CTRL_SCHED_WATCHDOG_EN
      cnt_q    <= '0;
      errTo_q  <= '0;
`endif
    end else begin
      sta_q  <= 1'b0;
      done_q <= 1'b0;
      if (step_start && state_q != IDLE) ovr_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (step_start) begin
            pend_q  <= ch_en;
            valid_q <= '0;
            busy_q  <= 1'b1;
            if (ch_en == '0) begin
              state_q <= FIN;
              done_q  <= 1'b1;
            end else begin
              state_q <= ISSUE;
              sta_q   <= 1'b1;
              sel_q   <= issueIdx_d;
              ops_q   <= issueOps_d;
            end
          end
        end
        ISSUE: begin
          state_q <= WAIT;
`ifdef CTRL_SCHED_WATCHDOG_EN
          cnt_q   <= '0;
`endif
        end
        // dp_done takes priority over a watchdog expiry landing on the same edge.
        WAIT: begin
          if (dp_done || timedOut_d) begin
            pend_q <= pendAfter_d;
            if (dp_done) begin
              resOne_q[int'(sel_q)*WIDTH +: WIDTH] <= dp_out_1;
              resTwo_q[int'(sel_q)*WIDTH +: WIDTH] <= dp_out_2;
              valid_q <= valid_q | curMask_d;
            end
`ifdef CTRL_SCHED_WATCHDOG_EN
            else errTo_q <= errTo_q | curMask_d;
`endif
            if (pendAfter_d != '0) begin
              state_q <= ISSUE;
              sta_q   <= 1'b1;
              sel_q   <= issueIdx_d;
              ops_q   <= issueOps_d;
            end else begin
              state_q <= FIN;
              done_q  <= 1'b1;
            end
          end
`ifdef CTRL_SCHED_WATCHDOG_EN
          else cnt_q <= cnt_q + CW'(1);
`endif
        end
        FIN: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dp_sel      = sel_q;
  assign dp_in_1     = ops_q[0*WIDTH +: WIDTH];
  assign dp_in_2     = ops_q[1*WIDTH +: WIDTH];
  assign dp_in_3     = ops_q[2*WIDTH +: WIDTH];
  assign dp_in_4     = ops_q[3*WIDTH +: WIDTH];
  assign dp_sta      = sta_q;
  assign res_1       = resOne_q;
  assign res_2       = resTwo_q;
  assign res_valid   = valid_q;
  assign step_done   = done_q;
  assign busy        = busy_q;
  assign err_overrun = ovr_q;

endmodule
